// File: rtl/lc4_pkg.sv
// Shared LC4 datapath definitions: NZP encodings, the NOP word and the M/W latch record.
// Imported by the writeback stage and by the NZP generator reused in X.
package lc4_pkg;

    localparam int unsigned LC4_XLEN = 16;

    localparam logic [2:0] NZP_N   = 3'b100;
    localparam logic [2:0] NZP_Z   = 3'b010;
    localparam logic [2:0] NZP_P   = 3'b001;
    localparam logic [2:0] NZP_RST = 3'b000;

    localparam logic [15:0] LC4_NOP = 16'h0000;

    // Everything the W stage needs about one instruction.
    typedef struct packed {
        logic                valid;
        logic [15:0]         pc;
        logic [15:0]         insn;
        logic [2:0]          rd;
        logic                rd_we;
        logic                nzp_we;
        logic [LC4_XLEN-1:0] result;
    } mw_latch_t;

endpackage

// File: rtl/lc4_nzp_gen.sv
// Maps a datapath result to its 3-bit NZP condition code (negative / zero / positive).
// Purely combinational; shared between the X and W stages.
module lc4_nzp_gen
    import lc4_pkg::*;
#(
    parameter int n = 16
) (
    input  logic [n-1:0] result,
    output logic [2:0]   nzp
);

    always_comb begin
        nzp = NZP_P;
        if (result[n-1]) begin
            nzp = NZP_N;
        end else if (result == '0) begin
            nzp = NZP_Z;
        end
    end

endmodule

// File: rtl/lc4_writeback_stage.sv
// LC4 writeback (W) stage: M/W latch, register-file write port, NZP register,
// retired-instruction counter and W->D read bypass.
module lc4_writeback_stage
    import lc4_pkg::*;
#(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         gwe,
    input  logic         i_valid,
    input  logic [15:0]  i_pc,
    input  logic [15:0]  i_insn,
    input  logic [2:0]   i_rd,
    input  logic         i_rd_we,
    input  logic         i_nzp_we,
    input  logic [n-1:0] i_result,
    input  logic         i_flush,
    output logic [2:0]   o_rd,
    output logic [n-1:0] o_wdata,
    output logic         o_rd_we,
    output logic         o_w_valid,
    output logic [15:0]  o_w_pc,
    output logic [15:0]  o_w_insn,
    output logic [2:0]   o_nzp,
    output logic [2:0]   o_nzp_next,
    input  logic [2:0]   i_rs,
    input  logic [2:0]   i_rt,
    input  logic [n-1:0] i_rs_rf,
    input  logic [n-1:0] i_rt_rf,
    output logic [n-1:0] o_rs_data,
    output logic [n-1:0] o_rt_data,
    output logic [31:0]  o_retired
);

    // The latch record carries LC4_XLEN result bits, so n must equal LC4_XLEN.
    mw_latch_t   w_q, w_d;
    logic [2:0]  nzp_q, nzp_d;
    logic [31:0] retired_q, retired_d;
    logic [2:0]  nzp_gen;
    logic        nzp_upd;

    lc4_nzp_gen #(.n(n)) u_nzp_gen (
        .result (w_q.result),
        .nzp    (nzp_gen)
    );

    assign nzp_upd = w_q.valid & w_q.nzp_we;

    always_comb begin
        w_d       = w_q;
        nzp_d     = nzp_q;
        retired_d = retired_q;
        if (gwe) begin
            if (i_flush) begin
                w_d      = '0;
                w_d.insn = LC4_NOP;
            end else begin
                w_d.valid  = i_valid;
                w_d.pc     = i_pc;
                w_d.insn   = i_insn;
                w_d.rd     = i_rd;
                w_d.rd_we  = i_rd_we;
                w_d.nzp_we = i_nzp_we;
                w_d.result = i_result;
            end
            if (nzp_upd) begin
                nzp_d = nzp_gen;
            end
            // The instruction in W retires at the edge that moves it out.
            if (w_q.valid) begin
                retired_d = retired_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q       <= '0;
            nzp_q     <= NZP_RST;
            retired_q <= '0;
        end else begin
            w_q       <= w_d;
            nzp_q     <= nzp_d;
            retired_q <= retired_d;
        end
    end

    assign o_rd       = w_q.rd;
    assign o_wdata    = w_q.result;
    assign o_rd_we    = w_q.valid & w_q.rd_we;
    assign o_w_valid  = w_q.valid;
    assign o_w_pc     = w_q.pc;
    assign o_w_insn   = w_q.insn;
    assign o_nzp      = nzp_q;
    assign o_nzp_next = nzp_upd ? nzp_gen : nzp_q;
    assign o_retired  = retired_q;

    assign o_rs_data = (o_rd_we && (i_rs == w_q.rd)) ? w_q.result : i_rs_rf;
    assign o_rt_data = (o_rd_we && (i_rt == w_q.rd)) ? w_q.result : i_rt_rf;

endmodule

// File: tb/tb_lc4_writeback_stage.sv
// Self-checking bench for lc4_writeback_stage: behavioural W-stage model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_lc4_writeback_stage;

    logic        clk = 1'b0;
    logic        rst, gwe;
    logic        i_valid, i_rd_we, i_nzp_we, i_flush;
    logic [15:0] i_pc, i_insn, i_result;
    logic [2:0]  i_rd, i_rs, i_rt;
    logic [15:0] i_rs_rf, i_rt_rf;
    logic [2:0]  o_rd, o_nzp, o_nzp_next;
    logic [15:0] o_wdata, o_w_pc, o_w_insn, o_rs_data, o_rt_data;
    logic        o_rd_we, o_w_valid;
    logic [31:0] o_retired;

    int errors = 0;
    int checks = 0;
    logic force_wrap = 1'b0;

    lc4_writeback_stage #(.n(16)) dut (
        .clk(clk), .rst(rst), .gwe(gwe),
        .i_valid(i_valid), .i_pc(i_pc), .i_insn(i_insn), .i_rd(i_rd),
        .i_rd_we(i_rd_we), .i_nzp_we(i_nzp_we), .i_result(i_result), .i_flush(i_flush),
        .o_rd(o_rd), .o_wdata(o_wdata), .o_rd_we(o_rd_we),
        .o_w_valid(o_w_valid), .o_w_pc(o_w_pc), .o_w_insn(o_w_insn),
        .o_nzp(o_nzp), .o_nzp_next(o_nzp_next),
        .i_rs(i_rs), .i_rt(i_rt), .i_rs_rf(i_rs_rf), .i_rt_rf(i_rt_rf),
        .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_retired(o_retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what W holds, the architectural NZP and the retirement count.
    logic        m_valid, m_rd_we, m_nzp_we;
    logic [15:0] m_pc, m_insn, m_result;
    logic [2:0]  m_rd, m_nzp;
    logic [31:0] m_ret;

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if ($signed(v) < 0)  return 3'b100;
        else if (v == 16'd0) return 3'b010;
        else                 return 3'b001;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 0; m_rd_we = 0; m_nzp_we = 0; m_pc = 0; m_insn = 0;
            m_rd = 0; m_result = 0; m_nzp = 3'b000; m_ret = 0;
        end else begin
            if (gwe) begin
                if (m_valid) m_ret = m_ret + 1;
                if (m_valid && m_nzp_we) m_nzp = nzp_of(m_result);
                if (i_flush) begin
                    m_valid = 0; m_rd_we = 0; m_nzp_we = 0; m_insn = 16'h0000; m_pc = 0;
                end else begin
                    m_valid = i_valid; m_rd_we = i_rd_we; m_nzp_we = i_nzp_we;
                    m_pc = i_pc; m_insn = i_insn; m_rd = i_rd; m_result = i_result;
                end
            end
            if (force_wrap) m_ret = 32'hFFFF_FFFF;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        logic       we_e;
        logic [2:0] nn_e;
        we_e = m_valid & m_rd_we;
        nn_e = (m_valid && m_nzp_we) ? nzp_of(m_result) : m_nzp;
        check("w_valid", {31'd0, o_w_valid}, {31'd0, m_valid});
        check("rd_we", {31'd0, o_rd_we}, {31'd0, we_e});
        check("w_pc", {16'd0, o_w_pc}, {16'd0, m_pc});
        check("w_insn", {16'd0, o_w_insn}, {16'd0, m_insn});
        if (m_valid) begin
            check("rd", {29'd0, o_rd}, {29'd0, m_rd});
            check("wdata", {16'd0, o_wdata}, {16'd0, m_result});
        end
        check("nzp", {29'd0, o_nzp}, {29'd0, m_nzp});
        check("nzp_next", {29'd0, o_nzp_next}, {29'd0, nn_e});
        check("rs_data", {16'd0, o_rs_data},
              {16'd0, (we_e && i_rs == m_rd) ? m_result : i_rs_rf});
        check("rt_data", {16'd0, o_rt_data},
              {16'd0, (we_e && i_rt == m_rd) ? m_result : i_rt_rf});
        check("retired", o_retired, m_ret);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [2:0] rd, input logic rd_we,
                         input logic nzp_we, input logic [15:0] res, input logic fl);
        i_valid = v; i_rd = rd; i_rd_we = rd_we; i_nzp_we = nzp_we;
        i_result = res; i_flush = fl;
        i_pc = 16'h3000 + {13'd0, rd}; i_insn = res ^ 16'h5A5A;
    endtask

    initial begin
        logic [31:0] r0;
        logic [2:0]  n0;
        rst = 1; gwe = 1;
        drive(0, 0, 0, 0, 16'h0, 0);
        i_rs = 0; i_rt = 0; i_rs_rf = 16'hAAAA; i_rt_rf = 16'h5555;
        @(negedge clk);
        check("reset_retired", o_retired, 32'd0);
        check("reset_nzp", {29'd0, o_nzp_next}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 0;

        // Write then bypass, followed by a bubble.
        drive(1, 3'd3, 1, 0, 16'h1234, 0);
        step();
        drive(0, 3'd0, 0, 0, 16'h0, 0);
        i_rs = 3; i_rt = 3; i_rs_rf = 16'h0000; i_rt_rf = 16'hBEEF;
        @(negedge clk);
        check("dir_rd_we", {31'd0, o_rd_we}, 32'd1);
        check("dir_rd", {29'd0, o_rd}, 32'd3);
        check("dir_rs_byp", {16'd0, o_rs_data}, 32'h1234);
        check("dir_rt_byp", {16'd0, o_rt_data}, 32'h1234);
        step();
        i_rs_rf = 16'hBEEF;
        @(negedge clk);
        check("dir_rd_we_off", {31'd0, o_rd_we}, 32'd0);
        check("dir_rs_raw", {16'd0, o_rs_data}, 32'hBEEF);

        // NZP sequence N, Z, P, then a non-NZP writer.
        drive(1, 1, 1, 1, 16'h8000, 0); step();
        drive(1, 2, 1, 1, 16'h0000, 0);
        @(negedge clk);
        check("nzp_next_n", {29'd0, o_nzp_next}, 32'b100);
        step();
        drive(1, 4, 1, 1, 16'h0001, 0);
        @(negedge clk);
        check("nzp_next_z", {29'd0, o_nzp_next}, 32'b010);
        check("nzp_reg_n", {29'd0, o_nzp}, 32'b100);
        step();
        drive(1, 5, 1, 0, 16'h8888, 0);
        @(negedge clk);
        check("nzp_next_p", {29'd0, o_nzp_next}, 32'b001);
        check("nzp_reg_z", {29'd0, o_nzp}, 32'b010);
        step();
        drive(0, 0, 0, 0, 16'h0, 0);
        @(negedge clk);
        check("nzp_reg_p", {29'd0, o_nzp}, 32'b001);
        check("nzp_next_hold", {29'd0, o_nzp_next}, 32'b001);
        step();

        // Flush wins over a valid writer.
        r0 = o_retired; n0 = o_nzp;
        drive(1, 6, 1, 1, 16'h8000, 1); step();
        drive(0, 0, 0, 0, 16'h0, 0);
        @(negedge clk);
        check("flush_valid", {31'd0, o_w_valid}, 32'd0);
        check("flush_rd_we", {31'd0, o_rd_we}, 32'd0);
        check("flush_insn", {16'd0, o_w_insn}, 32'd0);
        step();
        @(negedge clk);
        check("flush_retired", o_retired, r0);
        check("flush_nzp", {29'd0, o_nzp}, {29'd0, n0});

        // gwe stall with a valid writer in W.
        drive(1, 5, 1, 1, 16'h8001, 0); step();
        r0 = o_retired; n0 = o_nzp;
        gwe = 0;
        drive(1, 2, 1, 1, 16'h0000, 0);
        repeat (3) step();
        @(negedge clk);
        check("stall_retired", o_retired, r0);
        check("stall_nzp", {29'd0, o_nzp}, {29'd0, n0});
        check("stall_wdata", {16'd0, o_wdata}, 32'h8001);
        check("stall_pc", {16'd0, o_w_pc}, 32'h3005);
        gwe = 1;
        drive(0, 0, 0, 0, 16'h0, 0);
        step();
        @(negedge clk);
        check("stall_release_ret", o_retired, r0 + 32'd1);
        check("stall_release_nzp", {29'd0, o_nzp}, 32'b100);

        // Asynchronous reset between edges.
        drive(1, 7, 1, 1, 16'h7777, 0); step();
        i_rs = 7; i_rs_rf = 16'h4321;
        #1 rst = 1;
        #1;
        check("arst_valid", {31'd0, o_w_valid}, 32'd0);
        check("arst_rd_we", {31'd0, o_rd_we}, 32'd0);
        check("arst_wdata", {16'd0, o_wdata}, 32'd0);
        check("arst_retired", o_retired, 32'd0);
        check("arst_nzp", {29'd0, o_nzp}, 32'd0);
        check("arst_byp", {16'd0, o_rs_data}, 32'h4321);
        rst = 0;
        step();

        // Counter wrap: preload all-ones, then retire one instruction.
        force dut.retired_d = 32'hFFFF_FFFF;
        force_wrap = 1;
        drive(1, 1, 1, 0, 16'h0042, 0);
        step();
        force_wrap = 0;
        release dut.retired_d;
        gwe = 0; #1 gwe = 1;
        drive(0, 0, 0, 0, 16'h0, 0);
        @(negedge clk);
        check("wrap_preload", o_retired, 32'hFFFF_FFFF);
        step();
        @(negedge clk);
        check("wrap_zero", o_retired, 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            logic [15:0] res;
            case ($urandom_range(0, 3))
                0:       res = 16'h0000;
                1:       res = 16'h8000 | 16'($urandom);
                default: res = 16'($urandom);
            endcase
            gwe = ($urandom_range(0, 99) < 85);
            drive($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom), 1'($urandom), res,
                  $urandom_range(0, 9) == 0);
            i_pc = 16'($urandom); i_insn = 16'($urandom);
            i_rs = 3'($urandom); i_rt = 3'($urandom);
            i_rs_rf = 16'($urandom); i_rt_rf = 16'($urandom);
            step();
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
